// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared encodings, field widths and FSM states for the FP32 issue controller
// Ports: none (package).
package fp32_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/fp32_issue_ctrl_if.sv
// rtl/fp32_issue_ctrl_if.sv - request, EU and response signals of the FP32 issue controller
// Ports: none; signals grouped as two requesters (REQn_*), EU issue/return (EU_*) and
// response (RSP_*). Modport master = controller side, slave = environment side.
interface fp32_issue_ctrl_if;

  logic                        REQ0_VALID;
  logic                        REQ0_READY;
  logic [31:0]                 REQ0_OP_A;
  logic [31:0]                 REQ0_OP_B;
  logic [1:0]                  REQ0_OPCODE;
  logic                        REQ1_VALID;
  logic                        REQ1_READY;
  logic [31:0]                 REQ1_OP_A;
  logic [31:0]                 REQ1_OP_B;
  logic [1:0]                  REQ1_OPCODE;

  logic                        EU_START;
  logic [1:0]                  EU_OPCODE;
  logic                        EU_SIGN_A;
  logic                        EU_SIGN_B;
  logic [fp32_pkg::EXP_W-1:0]  EU_EXP_A;
  logic [fp32_pkg::EXP_W-1:0]  EU_EXP_B;
  logic [fp32_pkg::MANT_W-1:0] EU_MANT_A;
  logic [fp32_pkg::MANT_W-1:0] EU_MANT_B;
  logic                        EU_DONE;
  logic [31:0]                 EU_RESULT;

  logic                        RSP_VALID;
  logic                        RSP_READY;
  logic                        RSP_ID;
  logic [31:0]                 RSP_RESULT;
  logic                        RSP_ERR;

  modport master (
    input  REQ0_VALID, REQ0_OP_A, REQ0_OP_B, REQ0_OPCODE,
    input  REQ1_VALID, REQ1_OP_A, REQ1_OP_B, REQ1_OPCODE,
    output REQ0_READY, REQ1_READY,
    output EU_START, EU_OPCODE, EU_SIGN_A, EU_SIGN_B, EU_EXP_A, EU_EXP_B, EU_MANT_A, EU_MANT_B,
    input  EU_DONE, EU_RESULT,
    output RSP_VALID, RSP_ID, RSP_RESULT, RSP_ERR,
    input  RSP_READY
  );

  modport slave (
    output REQ0_VALID, REQ0_OP_A, REQ0_OP_B, REQ0_OPCODE,
    output REQ1_VALID, REQ1_OP_A, REQ1_OP_B, REQ1_OPCODE,
    input  REQ0_READY, REQ1_READY,
    input  EU_START, EU_OPCODE, EU_SIGN_A, EU_SIGN_B, EU_EXP_A, EU_EXP_B, EU_MANT_A, EU_MANT_B,
    output EU_DONE, EU_RESULT,
    input  RSP_VALID, RSP_ID, RSP_RESULT, RSP_ERR,
    output RSP_READY
  );

endinterface

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - combinational NaN/Inf/zero classification of one FP32 operand
// Ports: exp_in (biased exponent), mant_in (fraction) -> is_nan, is_inf, is_zero.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero
);

  assign is_nan  = (&exp_in) & (|mant_in);
  assign is_inf  = (&exp_in) & ~(|mant_in);
  assign is_zero = ~(|exp_in) & ~(|mant_in);

endmodule

// File: rtl/fp32_issue_ctrl.sv
// rtl/fp32_issue_ctrl.sv - round-robin issue controller sharing one FP32 EU between two requesters
// Ports: CLK, RST (async, active-high); bus (fp32_issue_ctrl_if.master): two request ports,
// EU start/fields/done/result, tagged valid/ready response.
// Parameter TIMEOUT_CYCLES (2..255): WAIT cycles before a watchdog error response.
// Macro FP32_SPECIAL_BYPASS_EN: resolve NaN/Inf special cases here instead of in the EU.
module fp32_issue_ctrl
  import fp32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RST,
  fp32_issue_ctrl_if.master  bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          eu_opcode_q, eu_opcode_d;
  logic                eu_sign_a_q, eu_sign_a_d;
  logic                eu_sign_b_q, eu_sign_b_d;
  logic [EXP_W-1:0]    eu_exp_a_q, eu_exp_a_d;
  logic [EXP_W-1:0]    eu_exp_b_q, eu_exp_b_d;
  logic [MANT_W-1:0]   eu_mant_a_q, eu_mant_a_d;
  logic [MANT_W-1:0]   eu_mant_b_q, eu_mant_b_d;
  logic                rsp_id_q, rsp_id_d;
  logic [31:0]         rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;

  logic                sel_valid, sel_id, hs;
  logic [31:0]         op_a, op_b;
  logic [1:0]          opc;
  logic                eff_sign_b;
  logic                byp_hit;
  logic [31:0]         byp_result;

  // With both requesters valid the RR pointer decides; otherwise the lone valid one wins.
  always_comb begin
    sel_valid  = bus.REQ0_VALID | bus.REQ1_VALID;
    sel_id     = (bus.REQ0_VALID & bus.REQ1_VALID) ? rr_q : bus.REQ1_VALID;
    op_a       = sel_id ? bus.REQ1_OP_A   : bus.REQ0_OP_A;
    op_b       = sel_id ? bus.REQ1_OP_B   : bus.REQ0_OP_B;
    opc        = sel_id ? bus.REQ1_OPCODE : bus.REQ0_OPCODE;
    eff_sign_b = op_b[31] ^ (opc == OP_SUB);
  end

  assign hs = (state_q == ST_IDLE) & sel_valid;

`ifdef FP32_SPECIAL_BYPASS_EN
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  fp32_classify u_cls_a (.exp_in(op_a[30:23]), .mant_in(op_a[22:0]),
                         .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
  fp32_classify u_cls_b (.exp_in(op_b[30:23]), .mant_in(op_b[22:0]),
                         .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

  always_comb begin
    byp_hit    = 1'b0;
    byp_result = '0;
    if (a_nan | b_nan) begin
      byp_hit    = 1'b1;
      byp_result = QNAN;
    end else if (opc == OP_MUL) begin
      if ((a_inf & b_zero) | (b_inf & a_zero)) begin
        byp_hit    = 1'b1;
        byp_result = QNAN;
      end else if (a_inf | b_inf) begin
        byp_hit    = 1'b1;
        byp_result = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
      end
    end else begin
      // Add/sub: signs compared after folding the subtraction into B's sign.
      if (a_inf & b_inf & (op_a[31] != eff_sign_b)) begin
        byp_hit    = 1'b1;
        byp_result = QNAN;
      end else if (a_inf) begin
        byp_hit    = 1'b1;
        byp_result = {op_a[31], 8'hFF, 23'd0};
      end else if (b_inf) begin
        byp_hit    = 1'b1;
        byp_result = {eff_sign_b, 8'hFF, 23'd0};
      end
    end
  end
`else
  assign byp_hit    = 1'b0;
  assign byp_result = '0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    eu_opcode_d  = eu_opcode_q;
    eu_sign_a_d  = eu_sign_a_q;
    eu_sign_b_d  = eu_sign_b_q;
    eu_exp_a_d   = eu_exp_a_q;
    eu_exp_b_d   = eu_exp_b_q;
    eu_mant_a_d  = eu_mant_a_q;
    eu_mant_b_d  = eu_mant_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          rr_d        = ~sel_id;
          rsp_id_d    = sel_id;
          eu_opcode_d = (opc == OP_MUL) ? OP_MUL : OP_ADD;
          eu_sign_a_d = op_a[31];
          eu_sign_b_d = eff_sign_b;
          eu_exp_a_d  = op_a[30:23];
          eu_exp_b_d  = op_b[30:23];
          eu_mant_a_d = op_a[22:0];
          eu_mant_b_d = op_b[22:0];
          if (opc == OP_RSV) begin
            rsp_result_d = QNAN;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end else if (byp_hit) begin
            rsp_result_d = byp_result;
            rsp_err_d    = 1'b0;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // EU_DONE is checked first so it wins over a coinciding timeout.
        if (bus.EU_DONE) begin
          rsp_result_d = bus.EU_RESULT;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (bus.RSP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
      eu_opcode_q  <= '0;
      eu_sign_a_q  <= 1'b0;
      eu_sign_b_q  <= 1'b0;
      eu_exp_a_q   <= '0;
      eu_exp_b_q   <= '0;
      eu_mant_a_q  <= '0;
      eu_mant_b_q  <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      eu_opcode_q  <= eu_opcode_d;
      eu_sign_a_q  <= eu_sign_a_d;
      eu_sign_b_q  <= eu_sign_b_d;
      eu_exp_a_q   <= eu_exp_a_d;
      eu_exp_b_q   <= eu_exp_b_d;
      eu_mant_a_q  <= eu_mant_a_d;
      eu_mant_b_q  <= eu_mant_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.REQ0_READY = hs & ~sel_id;
  assign bus.REQ1_READY = hs & sel_id;
  assign bus.EU_START   = (state_q == ST_ISSUE);
  assign bus.EU_OPCODE  = eu_opcode_q;
  assign bus.EU_SIGN_A  = eu_sign_a_q;
  assign bus.EU_SIGN_B  = eu_sign_b_q;
  assign bus.EU_EXP_A   = eu_exp_a_q;
  assign bus.EU_EXP_B   = eu_exp_b_q;
  assign bus.EU_MANT_A  = eu_mant_a_q;
  assign bus.EU_MANT_B  = eu_mant_b_q;
  assign bus.RSP_VALID  = (state_q == ST_RESP);
  assign bus.RSP_ID     = rsp_id_q;
  assign bus.RSP_RESULT = rsp_result_q;
  assign bus.RSP_ERR    = rsp_err_q;

endmodule

// File: tb/tb_fp32_issue_ctrl.sv
// tb/tb_fp32_issue_ctrl.sv - scoreboard bench for fp32_issue_ctrl (TIMEOUT_CYCLES=8)
module tb_fp32_issue_ctrl;
  import fp32_pkg::*;

  localparam int TMO = 8;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_issue_ctrl_if bus();

  fp32_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  bit          eu_en = 1'b0;
  int          eu_lat = 1;
  logic [31:0] eu_res = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [127:0] outs();
    return {bus.EU_START, bus.EU_OPCODE, bus.EU_SIGN_A, bus.EU_SIGN_B, bus.EU_EXP_A, bus.EU_EXP_B,
            bus.EU_MANT_A, bus.EU_MANT_B, bus.RSP_VALID, bus.RSP_ID, bus.RSP_RESULT, bus.RSP_ERR,
            bus.REQ0_READY, bus.REQ1_READY};
  endfunction

  // Response monitor: pops the scoreboard on each accepted response, checks stability while stalled.
  initial begin : monitor
    rsp_t prev;
    rsp_t got;
    bit   held;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.EU_START === 1'b1) start_cnt++;
      if (bus.RSP_VALID === 1'b1) begin
        got = {bus.RSP_ID, bus.RSP_RESULT, bus.RSP_ERR};
        if (held) check("rsp_stable", got, prev);
        if (bus.RSP_READY === 1'b1) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %0h expected no response", got);
          end else begin
            check("rsp", got, exp_q.pop_front());
          end
        end else begin
          held = 1'b1;
          prev = got;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // EU model: answers each EU_START with eu_res after eu_lat cycles.
  initial begin : eu_model
    bus.EU_DONE   = 1'b0;
    bus.EU_RESULT = '0;
    forever begin
      @(negedge clk);
      if (eu_en && bus.EU_START === 1'b1) begin
        repeat (eu_lat) @(negedge clk);
        if (!rst) begin
          bus.EU_DONE   = 1'b1;
          bus.EU_RESULT = eu_res;
          @(negedge clk);
          bus.EU_DONE = 1'b0;
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] opc);
    if (id == 1'b0) begin
      bus.REQ0_VALID = v; bus.REQ0_OP_A = a; bus.REQ0_OP_B = b; bus.REQ0_OPCODE = opc;
    end else begin
      bus.REQ1_VALID = v; bus.REQ1_OP_A = a; bus.REQ1_OP_B = b; bus.REQ1_OPCODE = opc;
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the handshake.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] opc);
    int n;
    n = 0;
    set_req(id, 1'b1, a, b, opc);
    #1;
    while (!(bus.REQ0_READY || bus.REQ1_READY) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("grant_ready", {bus.REQ1_READY, bus.REQ0_READY}, id ? 2'b10 : 2'b01);
    @(negedge clk);
    set_req(id, 1'b0, a, b, opc);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic quiet(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check(name, {bus.RSP_VALID, bus.EU_START}, 2'b00);
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int n;
    int s0;
    set_req(1'b0, 1'b0, '0, '0, OP_ADD);
    set_req(1'b1, 1'b0, '0, '0, OP_ADD);
    bus.RSP_READY = 1'b1;

    @(negedge clk); #1;
    check("reset_outputs", outs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // 1.0 + 2.0 through the EU with 3-cycle latency
    eu_en = 1'b1; eu_lat = 3; eu_res = 32'h4040_0000;
    s0 = start_cnt;
    exp_q.push_back({1'b0, 32'h4040_0000, 1'b0});
    issue(1'b0, 32'h3F80_0000, 32'h4000_0000, OP_ADD);
    #1;
    check("t1_start", bus.EU_START, 1'b1);
    check("t1_exp_a", bus.EU_EXP_A, 8'd127);
    check("t1_exp_b", bus.EU_EXP_B, 8'd128);
    check("t1_opcode", bus.EU_OPCODE, OP_ADD);
    drain();
    check("t1_start_once", start_cnt - s0, 1);

    // Round-robin with both requesters held valid after reset
    do_reset();
    eu_lat = 1; eu_res = 32'h1234_5678;
    set_req(1'b0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, OP_ADD);
    set_req(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, OP_MUL);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (!(bus.REQ0_READY || bus.REQ1_READY) && n < 50) begin
        @(negedge clk); #1; n++;
      end
      check("arb_grant", {bus.REQ1_READY, bus.REQ0_READY}, (k % 2 == 1) ? 2'b10 : 2'b01);
      exp_q.push_back({(k % 2 == 1), 32'h1234_5678, 1'b0});
      @(negedge clk);
      if (k == 3) begin
        bus.REQ0_VALID = 1'b0;
        bus.REQ1_VALID = 1'b0;
      end
    end
    drain();

    // 1.0 - 1.0 from requester 1: issued as add with B's sign flipped
    eu_lat = 2; eu_res = 32'h0000_0000;
    exp_q.push_back({1'b1, 32'h0000_0000, 1'b0});
    issue(1'b1, 32'h3F80_0000, 32'h3F80_0000, OP_SUB);
    #1;
    check("sub_start", bus.EU_START, 1'b1);
    check("sub_opcode", bus.EU_OPCODE, OP_ADD);
    check("sub_signs", {bus.EU_SIGN_A, bus.EU_SIGN_B}, 2'b01);
    drain();

    // Watchdog: EU silent, response TMO+2 cycles after the handshake
    eu_en = 1'b0;
    exp_q.push_back({1'b0, QNAN, 1'b1});
    issue(1'b0, 32'h4000_0000, 32'h4040_0000, OP_MUL);
    n = 1;
    #1;
    check("tmo_opcode", bus.EU_OPCODE, OP_MUL);
    while (bus.RSP_VALID !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("tmo_latency", n, TMO + 2);
    drain();
    bus.EU_DONE = 1'b1; bus.EU_RESULT = 32'h4100_0000;
    @(negedge clk);
    bus.EU_DONE = 1'b0;
    quiet("late_done_ignored", 4);

    // Reserved opcode answers directly, no EU_START
    s0 = start_cnt;
    exp_q.push_back({1'b1, QNAN, 1'b1});
    issue(1'b1, 32'h0000_0001, 32'h0000_0002, OP_RSV);
    #1;
    check("rsv_latency", bus.RSP_VALID, 1'b1);
    drain();
    check("rsv_no_start", start_cnt - s0, 0);

    // Response stalled 5 cycles; a waiting request is not accepted in RESP
    eu_en = 1'b1; eu_lat = 1; eu_res = 32'hCAFE_F00D;
    bus.RSP_READY = 1'b0;
    exp_q.push_back({1'b0, 32'hCAFE_F00D, 1'b0});
    issue(1'b0, 32'h4080_0000, 32'h3F00_0000, OP_ADD);
    n = 0;
    #1;
    while (bus.RSP_VALID !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("stall_valid", bus.RSP_VALID, 1'b1);
    set_req(1'b1, 1'b1, 32'h0, 32'h0, OP_RSV);
    for (int i = 0; i < 5; i++) begin
      check("stall_no_ready", {bus.REQ1_READY, bus.REQ0_READY}, 2'b00);
      @(negedge clk); #1;
    end
    bus.RSP_READY = 1'b1;
    #1;
    check("resp_exit_no_ready", {bus.REQ1_READY, bus.REQ0_READY}, 2'b00);
    exp_q.push_back({1'b1, QNAN, 1'b1});
    @(negedge clk); #1;
    check("post_resp_grant", {bus.REQ1_READY, bus.REQ0_READY}, 2'b10);
    @(negedge clk);
    bus.REQ1_VALID = 1'b0;
    drain();

    // Reset while in WAIT aborts; EU_DONE right after release is ignored
    eu_en = 1'b0;
    issue(1'b0, 32'h3F80_0000, 32'h3F80_0000, OP_ADD);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_outputs", outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    bus.EU_DONE = 1'b1; bus.EU_RESULT = 32'h4040_0000;
    @(negedge clk);
    bus.EU_DONE = 1'b0;
    quiet("post_reset_quiet", 4);

`ifdef FP32_SPECIAL_BYPASS_EN
    // Special operands resolved without the EU
    s0 = start_cnt;
    exp_q.push_back({1'b0, QNAN, 1'b0});
    issue(1'b0, 32'h7F80_0000, 32'h0000_0000, OP_MUL);
    #1;
    check("byp_latency", {bus.RSP_VALID, bus.EU_START}, 2'b10);
    drain();
    exp_q.push_back({1'b1, 32'hFF80_0000, 1'b0});
    issue(1'b1, 32'hFF80_0000, 32'h3F80_0000, OP_ADD);
    drain();
    check("byp_no_start", start_cnt - s0, 0);
`endif

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
